// File: rtl/rx_fifo_if.sv
// rx_fifo_if: receiver/controller-side signal bundle for the Rx FIFO
interface rx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic                  clear_i;
    logic                  push_i;
    logic [DATA_W-1:0]     push_data_i;
    logic                  pop_i;
    logic [DATA_W-1:0]     pop_data_o;
    logic                  full_o;
    logic                  empty_o;
    logic [DEPTH_LOG2:0]   level_o;
    logic                  overflow_o;
    logic                  underflow_o;
    logic [DEPTH_LOG2:0]   thresh_i;
    logic                  thresh_o;

    modport master (
        output clear_i, push_i, push_data_i, pop_i, thresh_i,
        input  pop_data_o, full_o, empty_o, level_o, overflow_o, underflow_o, thresh_o
    );

    modport slave (
        input  clear_i, push_i, push_data_i, pop_i, thresh_i,
        output pop_data_o, full_o, empty_o, level_o, overflow_o, underflow_o, thresh_o
    );
endinterface

// File: rtl/rx_fifo.sv
// rx_fifo: first-word fall-through receive FIFO with sticky overflow/underflow flags.
// Optional fill-threshold flag is built only when RX_FIFO_THRESH_EN is defined.
module rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input logic       clk_i,
    input logic       rst_i,
    rx_fifo_if.slave  bus
);
    localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

    logic [DATA_W-1:0]     mem_q [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  full, empty, do_push, do_pop;

    assign full  = level_q == DEPTH_L;
    assign empty = level_q == '0;

    // next-state: a pop on a full FIFO frees the slot for a same-cycle push; clear wins over both
    always_comb begin
        do_push = bus.push_i && (!full || bus.pop_i);
        do_pop  = bus.pop_i && !empty;
        wr_d    = bus.clear_i ? '0 : wr_q + DEPTH_LOG2'(do_push);
        rd_d    = bus.clear_i ? '0 : rd_q + DEPTH_LOG2'(do_pop);
        level_d = bus.clear_i ? '0 : level_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        ovf_d   = !bus.clear_i && (ovf_q || (bus.push_i && full && !bus.pop_i));
        udf_d   = !bus.clear_i && (udf_q || (bus.pop_i && empty));
    end

    // pointer, level and sticky flag registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // storage array; contents deliberately not reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && !bus.clear_i && do_push) mem_q[wr_q] <= bus.push_data_i;
    end

    assign bus.pop_data_o  = empty ? '0 : mem_q[rd_q];
    assign bus.full_o      = full;
    assign bus.empty_o     = empty;
    assign bus.level_o     = level_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = udf_q;

`ifdef RX_FIFO_THRESH_EN
    logic thr_q, thr_d;

    // threshold compare against the level the FIFO will hold after this edge
    always_comb thr_d = (bus.thresh_i != '0) && (level_d >= bus.thresh_i);

    // registered threshold indication
    always_ff @(posedge clk_i) begin
        if (rst_i) thr_q <= 1'b0;
        else       thr_q <= thr_d;
    end

    assign bus.thresh_o = thr_q;
`else
    assign bus.thresh_o = 1'b0;
`endif
endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed and random checks of rx_fifo against a queue-based model
module tb_rx_fifo;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_fifo_if #(.DATA_W(8), .DEPTH_LOG2(4)) bus ();
    rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    byte unsigned q[$];
    bit           m_ovf, m_udf, m_thr;
    int           errs = 0;
    int           checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":level"}, 32'(bus.level_o), 32'(q.size()));
        chk({ctx, ":empty"}, 32'(bus.empty_o), 32'(q.size() == 0));
        chk({ctx, ":full"}, 32'(bus.full_o), 32'(q.size() == 16));
        chk({ctx, ":ovf"}, 32'(bus.overflow_o), 32'(m_ovf));
        chk({ctx, ":udf"}, 32'(bus.underflow_o), 32'(m_udf));
        chk({ctx, ":head"}, 32'(bus.pop_data_o), q.size() != 0 ? 32'(q[0]) : 32'h0);
        chk({ctx, ":thr"}, 32'(bus.thresh_o), 32'(m_thr));
    endtask

    task automatic step(input bit pu, input byte unsigned d, input bit po, input bit cl, input string ctx);
        int  th;
        bit  pop_ok;
        @(negedge clk);
        bus.push_i = pu;
        bus.push_data_i = d;
        bus.pop_i = po;
        bus.clear_i = cl;
        @(posedge clk);
        th = int'(bus.thresh_i);
        if (cl) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            pop_ok = po && q.size() > 0;
            if (po && q.size() == 0) m_udf = 1;
            if (pop_ok) void'(q.pop_front());
            if (pu) begin
                if (q.size() < 16) q.push_back(d);
                else m_ovf = 1;
            end
        end
`ifdef RX_FIFO_THRESH_EN
        m_thr = (th != 0) && (q.size() >= th);
`else
        m_thr = 0;
`endif
        #1 check_all(ctx);
    endtask

    task automatic do_reset(input string ctx);
        @(negedge clk);
        rst = 1'b1;
        bus.push_i = 1'b1;
        bus.pop_i = 1'b1;
        @(posedge clk);
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_thr = 0;
        #1 check_all(ctx);
        @(negedge clk);
        rst = 1'b0;
        bus.push_i = 1'b0;
        bus.pop_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.clear_i = 1'b0;
        bus.push_i = 1'b0;
        bus.push_data_i = '0;
        bus.pop_i = 1'b0;
        bus.thresh_i = '0;
        do_reset("reset");
        step(0, 8'h00, 0, 0, "idle");
        // in-order delivery
        step(1, 8'h11, 0, 0, "t2push");
        step(1, 8'h22, 0, 0, "t2push");
        step(1, 8'h33, 0, 0, "t2push");
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, "t2pop");
        // fill, overflow, drain
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, "t3fill");
        step(1, 8'hAA, 0, 0, "t3ovf");
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, "t3drain");
        step(0, 8'h00, 0, 1, "t3clear");
        // push+pop while full, with pointer wrap
        for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0, "t4fill");
        step(1, 8'h55, 1, 0, "t4both");
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, "t4drain");
        // underflow, push+pop on empty, clear
        step(0, 8'h00, 1, 0, "t5udf");
        step(1, 8'h77, 1, 0, "t5both");
        step(1, 8'h78, 1, 1, "t5clear");
        // threshold
        bus.thresh_i = 5'd4;
        for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, 0, "t6push");
        step(0, 8'h00, 1, 0, "t6pop");
        bus.thresh_i = 5'd0;
        step(1, 8'h50, 0, 0, "t6zero");
        bus.thresh_i = 5'd20;
        for (int i = 0; i < 14; i++) step(1, 8'(i), 0, 0, "t6big");
        step(0, 8'h00, 0, 1, "t6clear");
        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) bus.thresh_i = 5'($urandom_range(0, 18));
            step(bit'($urandom_range(0, 9) < (i % 200 < 100 ? 7 : 3)), 8'($urandom),
                 bit'($urandom_range(0, 9) < (i % 200 < 100 ? 3 : 7)),
                 bit'($urandom_range(0, 79) == 0), "rand");
        end
        // reset mid-stream
        for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0, 0, "midfill");
        do_reset("midrst");
        step(0, 8'h00, 0, 0, "postrst");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
